// File: rtl/cache_nway_plru.sv
// N-way set-associative, write-back, write-allocate cache with tree pseudo-LRU replacement.
// Define CACHE_PERF_CNT_EN to add hit/miss/writeback counter outputs.
module cache_nway_plru #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned num_ways = 4,
  localparam int unsigned s_tag   = 32 - s_offset - s_index,
  localparam int unsigned s_line  = 8 * (2 ** s_offset)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_byte_enable,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  input  logic [s_line-1:0] pmem_rdata,
  output logic [s_line-1:0] pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);

  localparam int unsigned num_sets = 2 ** s_index;
  localparam int unsigned lw       = $clog2(num_ways);

  typedef enum logic [1:0] {StCheck, StWriteback, StFill} state_e;

  state_e              state_q;
  logic [num_ways-1:0] valid_q [num_sets];
  logic [num_ways-1:0] dirty_q [num_sets];
  logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
  logic [s_line-1:0]   data_q  [num_sets][num_ways];
  logic [num_ways-2:0] plru_q  [num_sets];

  logic [lw-1:0] victim_q;
  logic          pmem_read_q;
  logic          pmem_write_q;
  logic [31:0]   paddr_q;

  logic [s_tag-1:0]    req_tag;
  logic [s_index-1:0]  req_idx;
  logic [s_offset-1:0] req_off;
  logic                req_valid;
  logic                req_write;
  logic [31:0]         fill_addr;

  assign req_tag   = mem_address[31 -: s_tag];
  assign req_idx   = mem_address[s_offset +: s_index];
  assign req_off   = mem_address[s_offset-1:0];
  assign req_valid = mem_read | mem_write;
  assign req_write = mem_write;
  assign fill_addr = {req_tag, req_idx, {s_offset{1'b0}}};

  // Tag lookup
  logic          hit;
  logic [lw-1:0] hit_way;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = lw'(w);
      end
    end
  end

  // Victim: lowest invalid way, else follow the PLRU tree (bit 0 = left)
  logic [lw-1:0] victim;
  logic          victim_dirty;
  always_comb begin
    int unsigned node;
    node = 0;
    for (int l = 0; l < lw; l++) begin
      node = 2 * node + 1 + 32'(plru_q[req_idx][node[lw-1:0]]);
    end
    victim = lw'(node - (num_ways - 1));
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim = lw'(w);
    end
    victim_dirty = valid_q[req_idx][victim] & dirty_q[req_idx][victim];
  end

  // Word lane read, byte merge and PLRU path update for the hit way
  logic [s_line-1:0]   hit_line;
  logic [s_line-1:0]   merged_line;
  logic [num_ways-2:0] plru_next;
  always_comb begin
    int unsigned base;
    int unsigned node;
    int unsigned dir;
    hit_line    = data_q[req_idx][hit_way];
    base        = 32'(req_off >> 2) * 32;
    mem_rdata   = hit_line[base +: 32];
    merged_line = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) merged_line[base + 8 * b +: 8] = mem_wdata[8 * b +: 8];
    end
    plru_next = plru_q[req_idx];
    for (int l = 0; l < lw; l++) begin
      node = (32'd1 << l) - 32'd1 + (32'(hit_way) >> (lw - l));
      dir  = 32'(hit_way) >> (lw - 1 - l);
      plru_next[node[lw-1:0]] = ~dir[0];
    end
  end

  logic fill_done;
  assign mem_resp     = (state_q == StCheck) && req_valid && hit;
  assign fill_done    = (state_q == StFill) && pmem_resp;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = paddr_q;
  assign pmem_wdata   = data_q[req_idx][victim_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StCheck;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      victim_q     <= '0;
      paddr_q      <= '0;
    end else begin
      unique case (state_q)
        StCheck: begin
          if (req_valid && !hit) begin
            victim_q <= victim;
            if (victim_dirty) begin
              state_q      <= StWriteback;
              pmem_write_q <= 1'b1;
              paddr_q      <= {tag_q[req_idx][victim], req_idx, {s_offset{1'b0}}};
            end else begin
              state_q     <= StFill;
              pmem_read_q <= 1'b1;
              paddr_q     <= fill_addr;
            end
          end
        end
        StWriteback: begin
          if (pmem_resp) begin
            state_q      <= StFill;
            pmem_write_q <= 1'b0;
            pmem_read_q  <= 1'b1;
            paddr_q      <= fill_addr;
          end
        end
        StFill: begin
          if (pmem_resp) begin
            state_q     <= StCheck;
            pmem_read_q <= 1'b0;
          end
        end
        default: state_q <= StCheck;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (mem_resp) begin
      plru_q[req_idx] <= plru_next;
      if (req_write && (mem_byte_enable != 4'b0000)) dirty_q[req_idx][hit_way] <= 1'b1;
    end else if (fill_done) begin
      valid_q[req_idx][victim_q] <= 1'b1;
      dirty_q[req_idx][victim_q] <= 1'b0;
    end
  end

  // Tags and line data carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[req_idx][victim_q]  <= req_tag;
      data_q[req_idx][victim_q] <= pmem_rdata;
    end else if (mem_resp && req_write) begin
      data_q[req_idx][hit_way] <= merged_line;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic        missed_q;
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;
  logic [31:0] wb_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      missed_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      if ((state_q == StCheck) && req_valid && !hit) begin
        miss_count_q <= miss_count_q + 32'd1;
        missed_q     <= 1'b1;
      end
      if (mem_resp) begin
        if (!missed_q) hit_count_q <= hit_count_q + 32'd1;
        missed_q <= 1'b0;
      end
      if ((state_q == StWriteback) && pmem_resp) wb_count_q <= wb_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`endif

endmodule
